fir_mac_sched: RTL and testbench

FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_mac_sched_if.sv | 31 +++
 rtl/fir_mac.sv | 59 +++++
 rtl/fir_mac_sched.sv | 106 ++++++++++
 tb/tb_fir_mac_sched.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the time-shared FIR filter.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_N_TAPS  = 33;
   localparam int DEF_COEFF_W = 32;
   localparam int DEF_DATA_W  = 24;

   function automatic int ptr_w(input int n_taps);
      return $clog2(n_taps);
   endfunction

   // Headroom of clog2(N_TAPS) bits keeps the full-scale sum from wrapping.
   function automatic int acc_w(input int data_w, input int coeff_w, input int n_taps);
      return data_w + coeff_w + $clog2(n_taps);
   endfunction

   localparam int DEF_PTR_W = ptr_w(DEF_N_TAPS);
   localparam int DEF_ACC_W = acc_w(DEF_DATA_W, DEF_COEFF_W, DEF_N_TAPS);

endpackage

// File: rtl/fir_mac_sched_if.sv
// Sample stream, result stream and coefficient write port of the FIR scheduler.
interface fir_mac_sched_if
   import fir_pkg::*;
#(
   parameter int N_TAPS  = DEF_N_TAPS,
   parameter int COEFF_W = DEF_COEFF_W,
   parameter int DATA_W  = DEF_DATA_W
);
   localparam int AW = ptr_w(N_TAPS);

   logic [DATA_W-1:0]  in_data;
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  out_data;
   logic               out_valid;
   logic               out_ready;
   logic               coef_we;
   logic [AW-1:0]      coef_addr;
   logic [COEFF_W-1:0] coef_data;

   modport slave (
      input  in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
      output in_ready, out_data, out_valid
   );

   modport master (
      output in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
      input  in_ready, out_data, out_valid
   );

endinterface

// File: rtl/fir_mac.sv
// Single multiply-accumulate with clear and a saturating, rescaling output register.
module fir_mac
   import fir_pkg::*;
#(
   parameter int N_TAPS  = DEF_N_TAPS,
   parameter int COEFF_W = DEF_COEFF_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      en,
   input  logic                      load_out,
   input  logic signed [DATA_W-1:0]  sample,
   input  logic signed [COEFF_W-1:0] coef,
   output logic signed [DATA_W-1:0]  out_data
);
   localparam int PROD_W = DATA_W + COEFF_W;
   localparam int ACC_W  = acc_w(DATA_W, COEFF_W, N_TAPS);
   localparam int EXT_W  = ACC_W - PROD_W;

   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  scaled;
   logic signed [DATA_W-1:0] sat;

   assign prod     = sample * coef;
   assign acc_next = acc + {{EXT_W{prod[PROD_W-1]}}, prod};
   // Arithmetic shift floors, so negative results round toward minus infinity.
   assign scaled   = acc_next >>> (COEFF_W-1);

   always_comb begin
      sat = scaled[DATA_W-1:0];
      if (scaled > MAX_V)
         sat = MAX_V[DATA_W-1:0];
      else if (scaled < MIN_V)
         sat = MIN_V[DATA_W-1:0];
   end

   // The output loads from acc_next so the final tap lands in the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         out_data <= '0;
      end else begin
         if (clear)
            acc <= '0;
         else if (en)
            acc <= acc_next;
         if (load_out)
            out_data <= sat;
      end
   end

endmodule

// File: rtl/fir_mac_sched.sv
// Time-shared FIR: one MAC walks all taps per accepted sample, result held until taken.
//   state | meaning
//   IDLE  | ready for a sample; coefficient writes allowed
//   RUN   | one tap per cycle, k = 0 .. N_TAPS-1
//   DONE  | result presented, waiting for out_ready
module fir_mac_sched
   import fir_pkg::*;
#(
   parameter int N_TAPS  = DEF_N_TAPS,
   parameter int COEFF_W = DEF_COEFF_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic            clk,
   input  logic            reset,
   fir_mac_sched_if.slave  bus
);
   localparam int AW = ptr_w(N_TAPS);
   localparam logic [AW-1:0] LAST_IDX = AW'(N_TAPS-1);
   localparam logic [AW-1:0] N_MOD    = AW'(N_TAPS);

   state_t             state;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      k;
   logic [AW-1:0]      rd_idx;
   logic               last;
   logic               accept;
   logic [DATA_W-1:0]  history [N_TAPS];
   logic [COEFF_W-1:0] coef    [N_TAPS];

   assign accept = (state == IDLE) && bus.in_valid;
   assign last   = (k == LAST_IDX);
   // Modular arithmetic in AW bits lands in range because the true index is < N_TAPS.
   assign rd_idx = wr_ptr - k + ((wr_ptr < k) ? N_MOD : '0);

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         wr_ptr      <= '0;
         k           <= '0;
         for (int i = 0; i < N_TAPS; i++)
            history[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  history[wr_ptr] <= bus.in_data;
                  k               <= '0;
                  in_ready_q      <= 1'b0;
                  state           <= RUN;
               end
            end
            RUN: begin
               if (last) begin
                  k           <= '0;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   // Coefficients survive reset; only IDLE writes to a valid tap land.
   always_ff @(posedge clk) begin
      if (!reset && (state == IDLE) && bus.coef_we && (int'(bus.coef_addr) < N_TAPS))
         coef[bus.coef_addr] <= bus.coef_data;
   end

   fir_mac #(
      .N_TAPS  (N_TAPS),
      .COEFF_W (COEFF_W),
      .DATA_W  (DATA_W)
   ) u_mac (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .en       (state == RUN),
      .load_out ((state == RUN) && last),
      .sample   (history[rd_idx]),
      .coef     (coef[k]),
      .out_data (bus.out_data)
   );

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: expected outputs queued on send, checked on receive.
module tb_fir_mac_sched;
   import fir_pkg::*;

   localparam int N  = 33;
   localparam int CW = 32;
   localparam int DW = 24;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fir_mac_sched_if #(.N_TAPS(N), .COEFF_W(CW), .DATA_W(DW)) bus ();

   fir_mac_sched #(.N_TAPS(N), .COEFF_W(CW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int acc_cyc  = 0;
   int prev_acc = 0;
   logic [DW-1:0] sb [$];

   always @(posedge clk) cyc++;

   initial begin
      #600000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] imp_exp(input int n);
      return (n <= N-1) ? DW'(n * 32'h8000) : '0;
   endfunction

   function automatic logic [DW-1:0] sat_exp(input int n);
      int v;
      v = (n + 1) * 32'h100000;
      return (v > 32'h7FFFFF) ? 24'h7FFFFF : DW'(v);
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.coef_we   = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
   endtask

   task automatic write_coef(input int a, input logic [CW-1:0] v);
      bus.coef_we   = 1'b1;
      bus.coef_addr = a[5:0];
      bus.coef_data = v;
      @(negedge clk);
      bus.coef_we = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] exp);
      int t = 0;
      while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
      check("send_in_ready", bus.in_ready, 1'b1);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      sb.push_back(exp);
      @(negedge clk);
      bus.in_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic recv(input string tag, input bit chk_lat);
      int t = 0;
      logic [DW-1:0] e;
      while (!bus.out_valid && t < N + 20) begin @(negedge clk); t++; end
      check({tag, "_valid"}, bus.out_valid, 1'b1);
      if (chk_lat) check({tag, "_latency"}, t, N);
      if (sb.size() > 0) e = sb.pop_front();
      else e = 'x;
      check({tag, "_data"}, bus.out_data, e);
      @(negedge clk);
   endtask

   task automatic run_impulse(input string tag, input int count);
      for (int n = 0; n < count; n++) begin
         send((n == 0) ? 24'h400000 : 24'h000000, imp_exp(n));
         if (n > 0) check({tag, "_period"}, acc_cyc - prev_acc, N + 2);
         prev_acc = acc_cyc;
         recv(tag, 1'b1);
      end
   endtask

   initial begin
      logic [DW-1:0] held;
      bit saw_valid;
      int t;

      reset = 1'b1;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      repeat (3) @(negedge clk);
      check("reset_in_ready", bus.in_ready, 1'b1);
      check("reset_out_valid", bus.out_valid, 1'b0);
      check("reset_out_data", bus.out_data, 24'h0);
      reset = 1'b0;
      @(negedge clk);

      // Impulse response with wrap of the history ring
      for (int i = 0; i < N; i++) write_coef(i, CW'(i) << 24);
      run_impulse("impulse", 41);

      // Reset mid-RUN, with competing in_valid and coef_we held during reset
      send(24'h400000, 24'h0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 24'h400000;
      bus.coef_we   = 1'b1;
      bus.coef_addr = 6'd1;
      bus.coef_data = '0;
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
      sb.delete();
      check("midrun_in_ready", bus.in_ready, 1'b1);
      check("midrun_out_valid", bus.out_valid, 1'b0);
      saw_valid = 1'b0;
      repeat (N + 5) begin
         @(negedge clk);
         if (bus.out_valid) saw_valid = 1'b1;
      end
      check("midrun_no_pulse", saw_valid, 1'b0);
      run_impulse("post_reset", 35);

      // Coefficient write during RUN is ignored
      do_reset();
      send(24'h400000, imp_exp(0)); recv("gate_run", 1'b1);
      send(24'h000000, imp_exp(1)); recv("gate_run", 1'b1);
      send(24'h000000, imp_exp(2)); recv("gate_run", 1'b1);
      send(24'h000000, imp_exp(3));
      write_coef(3, CW'(20) << 24);
      recv("gate_run_tap3", 1'b0);

      // Same write coincident with acceptance is used for that sample
      do_reset();
      send(24'h400000, imp_exp(0)); recv("gate_idle", 1'b1);
      send(24'h000000, imp_exp(1)); recv("gate_idle", 1'b1);
      send(24'h000000, imp_exp(2)); recv("gate_idle", 1'b1);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 6'd3;
      bus.coef_data = CW'(20) << 24;
      send(24'h000000, 24'h0A0000);
      bus.coef_we = 1'b0;
      recv("gate_idle_tap3", 1'b1);
      write_coef(3, CW'(3) << 24);

      // Back-pressure in DONE with a pending sample held on the input
      do_reset();
      send(24'h400000, imp_exp(0)); recv("bp_pre", 1'b1);
      bus.out_ready = 1'b0;
      send(24'h000000, imp_exp(1));
      t = 0;
      while (!bus.out_valid && t < N + 20) begin @(negedge clk); t++; end
      held = sb.pop_front();
      bus.in_data  = 24'h000000;
      bus.in_valid = 1'b1;
      sb.push_back(imp_exp(2));
      repeat (10) begin
         check("bp_out_valid", bus.out_valid, 1'b1);
         check("bp_out_data", bus.out_data, held);
         check("bp_in_ready", bus.in_ready, 1'b0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", bus.out_valid, 1'b0);
      check("bp_release_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      recv("bp_pending", 1'b1);

      // Positive saturation
      for (int i = 0; i < N; i++) write_coef(i, 32'h40000000);
      do_reset();
      for (int n = 0; n < 12; n++) begin
         send(24'h200000, sat_exp(n));
         recv("sat_pos", 1'b1);
      end

      // Negative saturation
      do_reset();
      send(24'h800000, 24'hC00000); recv("sat_neg", 1'b1);
      send(24'h800000, 24'h800000); recv("sat_neg", 1'b1);
      send(24'h800000, 24'h800000); recv("sat_neg", 1'b1);

      // Rounding toward minus infinity
      for (int i = 0; i < N; i++) write_coef(i, (i == 0) ? 32'h1 : 32'h0);
      do_reset();
      send(24'hFFFFFF, 24'hFFFFFF); recv("floor_neg", 1'b1);
      send(24'h000001, 24'h000000); recv("floor_pos", 1'b1);

      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
